local_inject_arbiter: RTL and testbench

Round-robin arbiter sharing one router injection port among N local packet sources at a mesh node. Sits between the node's requesters (packet generators, DMA, core NI) and the router's single `inject`/`push_j`/`push_j_ack` interface. Captures one 64-bit flit from the granted requester into a holding register, presents it to the router, and counts completed injections.

---
 rtl/local_inject_arbiter.sv | 126 ++++++++++++
 tb/tb_local_inject_arbiter.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/local_inject_arbiter.sv
// Round-robin arbiter that funnels N local flit sources into one router inject port.
// One flit is captured per grant, held stable until the router acks, then counted.
module local_inject_arbiter #(
    parameter int N      = 4,
    parameter int FLIT_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req_push,
    input  logic [N*FLIT_W-1:0]  req_data,
    output logic [N-1:0]         req_ack,
    output logic                 push_j,
    output logic [FLIT_W-1:0]    inject,
    input  logic                 push_j_ack,
    output logic [$clog2(N)-1:0] grant_id,
    output logic                 busy,
    output logic [CNT_W-1:0]     pkt_count
);
    // state   | meaning
    // IDLE    | waiting for any req_push, round-robin search from ptr
    // ACK     | one-cycle req_ack pulse to the granted requester
    // SEND    | push_j high, holding the flit until push_j_ack
    localparam int GW = $clog2(N);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACK  = 2'd1;
    localparam logic [1:0] ST_SEND = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [GW-1:0]     ptr_q, ptr_d;
    logic [GW-1:0]     grant_q, grant_d;
    logic [FLIT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic              found;
    logic [GW-1:0]     pick;
    logic [GW:0]       probe;
    logic [FLIT_W-1:0] pick_data;

    // probe walks ptr, ptr+1, ... with one conditional subtract as the modulo
    always_comb begin
        found = 1'b0;
        pick  = '0;
        probe = '0;
        for (int k = 0; k < N; k++) begin
            probe = {1'b0, ptr_q} + (GW+1)'(k);
            if (probe >= (GW+1)'(N)) begin
                probe = probe - (GW+1)'(N);
            end
            if (!found && req_push[probe[GW-1:0]]) begin
                found = 1'b1;
                pick  = probe[GW-1:0];
            end
        end
    end

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < N; i++) begin
            if (pick == GW'(i)) begin
                pick_data = req_data[i*FLIT_W +: FLIT_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    hold_d  = pick_data;
                    grant_d = pick;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (push_j_ack) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    ptr_d   = (grant_q == GW'(N-1)) ? '0 : grant_q + GW'(1);
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // outputs decode registered state only, so reset clears them asynchronously
    always_comb begin
        req_ack = '0;
        if (state_q == ST_ACK) begin
            req_ack[grant_q] = 1'b1;
        end
    end

    assign push_j    = (state_q == ST_SEND);
    assign busy      = (state_q != ST_IDLE);
    assign inject    = hold_q;
    assign grant_id  = grant_q;
    assign pkt_count = cnt_q;

endmodule

// File: tb/tb_local_inject_arbiter.sv
// Bench for local_inject_arbiter: vector table plus hand-written corner sequences,
// with a scoreboard of expected injections checked whenever the router accepts a flit.
module tb_local_inject_arbiter;
    typedef struct {
        logic [3:0] mask;
        int         wait_cyc;
        logic [1:0] gid;
    } vec_t;

    typedef struct {
        logic [1:0]  gid;
        logic [63:0] data;
    } sb_t;

    localparam logic [63:0] FLITS [4] = '{
        64'h0000_0000_0000_00A5,
        64'hDEAD_BEEF_0000_0001,
        64'h0123_4567_89AB_CDEF,
        64'hFFFF_0000_FFFF_0003
    };

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req_push;
    logic [255:0] req_data;
    logic [3:0]   req_ack;
    logic         push_j;
    logic [63:0]  inject;
    logic         push_j_ack;
    logic [1:0]   grant_id;
    logic         busy;
    logic [15:0]  pkt_count;

    logic [3:0]   req_push_w;
    logic [3:0]   req_ack_w;
    logic         push_j_w;
    logic [63:0]  inject_w;
    logic         ack_w;
    logic [1:0]   grant_id_w;
    logic         busy_w;
    logic [3:0]   pkt_count_w;

    int  total = 0;
    int  bad   = 0;
    int  exp_cnt = 0;
    sb_t exp_q[$];
    sb_t mon_e;

    always #5 clk = ~clk;

    assign req_data = {FLITS[3], FLITS[2], FLITS[1], FLITS[0]};

    local_inject_arbiter #(.N(4), .FLIT_W(64), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .req_push(req_push), .req_data(req_data),
        .req_ack(req_ack), .push_j(push_j), .inject(inject), .push_j_ack(push_j_ack),
        .grant_id(grant_id), .busy(busy), .pkt_count(pkt_count)
    );

    local_inject_arbiter #(.N(4), .FLIT_W(64), .CNT_W(4)) u_wrap (
        .clk(clk), .reset(reset), .req_push(req_push_w), .req_data(req_data),
        .req_ack(req_ack_w), .push_j(push_j_w), .inject(inject_w), .push_j_ack(ack_w),
        .grant_id(grant_id_w), .busy(busy_w), .pkt_count(pkt_count_w)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // an accepted flit is visible at the negedge before the accepting edge
    always @(negedge clk) begin
        if (reset === 1'b0 && push_j === 1'b1 && push_j_ack === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got inject 0x%0h expected no injection", inject);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sb_gid", 64'(grant_id), 64'(mon_e.gid));
                chk("sb_data", inject, mon_e.data);
                exp_cnt++;
            end
        end
    end

    task automatic run_vec(input logic [3:0] mask, input int w, input logic [1:0] gid);
        sb_t e;
        e.gid  = gid;
        e.data = FLITS[gid];
        exp_q.push_back(e);
        req_push   = mask;
        push_j_ack = 1'b0;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ack_onehot", 64'(req_ack), 64'(4'b0001 << gid));
        chk("ack_push_j", 64'(push_j), 64'd0);
        chk("ack_grant_id", 64'(grant_id), 64'(gid));
        @(posedge clk); #1;
        repeat (w) begin
            @(negedge clk);
            chk("bp_push_j", 64'(push_j), 64'd1);
            chk("bp_inject", inject, FLITS[gid]);
            chk("bp_no_ack", 64'(req_ack), 64'd0);
            @(posedge clk); #1;
        end
        req_push   = 4'b0000;
        push_j_ack = 1'b1;
        @(negedge clk);
        chk("send_push_j", 64'(push_j), 64'd1);
        @(posedge clk); #1;
        push_j_ack = 1'b0;
        @(negedge clk);
        chk("done_busy", 64'(busy), 64'd0);
        chk("done_push_j", 64'(push_j), 64'd0);
        chk("done_count", 64'(pkt_count), 64'(exp_cnt));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        vec_t vt[10];
        sb_t  e;
        int   rr_order[6];
        int   ack_idx;
        int   n;
        int   cyc;

        vt[0] = '{4'b0001, 0,  2'd0};
        vt[1] = '{4'b0001, 0,  2'd0};
        vt[2] = '{4'b1111, 0,  2'd1};
        vt[3] = '{4'b0011, 0,  2'd0};
        vt[4] = '{4'b1000, 10, 2'd3};
        vt[5] = '{4'b1010, 0,  2'd1};
        vt[6] = '{4'b0110, 0,  2'd2};
        vt[7] = '{4'b0111, 2,  2'd0};
        vt[8] = '{4'b0100, 0,  2'd2};
        vt[9] = '{4'b1001, 0,  2'd3};
        rr_order = '{0, 1, 2, 3, 0, 1};

        reset      = 1'b1;
        req_push   = 4'b0000;
        push_j_ack = 1'b0;
        req_push_w = 4'b0000;
        ack_w      = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_push_j", 64'(push_j), 64'd0);
        chk("rst_req_ack", 64'(req_ack), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_inject", inject, 64'd0);
        chk("rst_count", 64'(pkt_count), 64'd0);
        chk("rst_grant_id", 64'(grant_id), 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vt[i].mask, vt[i].wait_cyc, vt[i].gid);
        end

        // spurious push_j_ack in IDLE, then held high through ACK
        push_j_ack = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_idle_busy", 64'(busy), 64'd0);
        chk("spur_idle_count", 64'(pkt_count), 64'(exp_cnt));
        e.gid = 2'd2; e.data = FLITS[2]; exp_q.push_back(e);
        req_push = 4'b0100;
        @(posedge clk); #1;
        @(negedge clk);
        chk("spur_ack_pulse", 64'(req_ack), 64'b0100);
        @(posedge clk); #1;
        req_push   = 4'b0000;
        push_j_ack = 1'b0;
        @(negedge clk);
        chk("spur_in_send", 64'(push_j), 64'd1);
        chk("spur_ack_count", 64'(pkt_count), 64'(exp_cnt));
        @(posedge clk); #1;
        push_j_ack = 1'b1;
        @(posedge clk); #1;
        push_j_ack = 1'b0;
        @(negedge clk);
        chk("spur_done_count", 64'(pkt_count), 64'(exp_cnt));

        // reset during ACK: ptr is 3 here, so requester 0 wins
        @(posedge clk); #1;
        req_push = 4'b0001;
        @(posedge clk); #1;
        chk("rack_pre", 64'(req_ack), 64'b0001);
        reset = 1'b1;
        #1;
        chk("rack_drop", 64'(req_ack), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        req_push = 4'b0000;
        exp_cnt  = 0;
        @(posedge clk); #1;

        run_vec(4'b0010, 0, 2'd1);

        // reset during SEND with ptr=2 and a nonzero count
        req_push = 4'b0100;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rsend_pre", 64'(push_j), 64'd1);
        reset = 1'b1;
        #1;
        chk("rsend_push_j", 64'(push_j), 64'd0);
        chk("rsend_req_ack", 64'(req_ack), 64'd0);
        chk("rsend_grant_id", 64'(grant_id), 64'd0);
        chk("rsend_count", 64'(pkt_count), 64'd0);
        chk("rsend_busy", 64'(busy), 64'd0);
        @(negedge clk);
        reset    = 1'b0;
        req_push = 4'b0000;
        exp_q.delete();
        exp_cnt = 0;
        @(posedge clk); #1;

        // continuous requests, zero-wait router: grants must start at 0 after reset
        for (int i = 0; i < 6; i++) begin
            e.gid = 2'(rr_order[i]); e.data = FLITS[rr_order[i]]; exp_q.push_back(e);
        end
        ack_idx    = 0;
        req_push   = 4'b1111;
        push_j_ack = 1'b1;
        repeat (18) begin
            @(negedge clk);
            if (req_ack !== 4'b0000) begin
                if (ack_idx < 6) begin
                    chk("rr_ack", 64'(req_ack), 64'(4'b0001 << rr_order[ack_idx]));
                end else begin
                    total++;
                    bad++;
                    $display("FAIL rr_extra_ack: got 0x%0h expected none", req_ack);
                end
                ack_idx++;
            end
            @(posedge clk);
        end
        #1;
        req_push   = 4'b0000;
        push_j_ack = 1'b0;
        @(negedge clk);
        chk("rr_ack_count", 64'(ack_idx), 64'd6);
        chk("rr_pkt_count", 64'(pkt_count), 64'd6);
        chk("rr_busy", 64'(busy), 64'd0);
        chk("sb_drain", 64'(exp_q.size()), 64'd0);

        // 4-bit counter: 17 injections leave it at 1
        @(posedge clk); #1;
        req_push_w = 4'b0001;
        ack_w      = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 17 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (push_j_w === 1'b1) n++;
        end
        @(posedge clk); #1;
        req_push_w = 4'b0000;
        ack_w      = 1'b0;
        @(negedge clk);
        chk("wrap_injections", 64'(n), 64'd17);
        chk("wrap_count", 64'(pkt_count_w), 64'd1);
        chk("wrap_busy", 64'(busy_w), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
